// File: rtl/mux_8to1_rr_pkg.sv
// mux_pkg: shared state type, default sizes and the round-robin pick helper
// used by the mux_8to1_rr gathering mux.
package mux_pkg;
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam int N_CH_DEF   = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_CH     = 16;
    // One-hot grant for the first valid channel after last_grant, wrapping at n.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                                  input logic [3:0] last_grant, input int n);
        logic [MAX_CH-1:0] g;
        logic [3:0] idx;
        g = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = 4'((int'(last_grant) + k) % n);
            if (k <= n && g == '0 && valid[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction
endpackage

// File: rtl/mux_8to1_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant plus the registered last-grant
// pointer, which moves to the granted channel whenever a beat is accepted.
module rr_arbiter import mux_pkg::*; #(
    parameter int  N_CH  = N_CH_DEF,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [MAX_CH-1:0] req_w, pick;
    always_comb begin
        req_w = '0;
        req_w[N_CH-1:0] = req;
        pick = rr_pick(req_w, 4'(ptr_q), N_CH);
        grant = pick[N_CH-1:0];
        grant_idx = '0;
        for (int i = 0; i < MAX_CH; i++) if (pick[i]) grant_idx = SEL_W'(i);
        ptr_d = advance ? grant_idx : ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= SEL_W'(N_CH - 1);
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mux_8to1_rr.sv
// mux_8to1_rr: round-robin N:1 stream merge with packet locking on last and a
// single-entry output register tagging each beat with its source channel.
module mux_8to1_rr import mux_pkg::*; #(
    parameter int  N_CH   = N_CH_DEF,
    parameter int  DATA_W = DATA_W_DEF,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         sel,
    input  logic                     out_ready,
    output logic                     busy
);
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  lock_q, lock_d, sel_q, sel_d, gidx;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic [N_CH-1:0]   req, grant;
    logic              load_en, xfer;
    // While locked only the owning channel may request, so arbitration cannot move.
    assign req     = (state_q == LOCKED) ? in_valid & (N_CH'(1) << lock_q) : in_valid;
    assign load_en = !valid_q || out_ready;
    assign xfer    = load_en && |grant;
    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (gidx)
    );
    always_comb begin
        valid_d = load_en ? xfer : valid_q;
        data_d  = xfer ? in_data[gidx*DATA_W +: DATA_W] : data_q;
        last_d  = xfer ? in_last[gidx] : last_q;
        sel_d   = xfer ? gidx : sel_q;
        lock_d  = (xfer && state_q == IDLE) ? gidx : lock_q;
        state_d = xfer ? (in_last[gidx] ? IDLE : LOCKED) : state_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end
    assign in_ready  = load_en ? grant : '0;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign sel       = sel_q;
    assign busy      = (state_q == LOCKED);
endmodule

// File: tb/tb_mux_8to1_rr.sv
// tb_mux_8to1_rr: directed and random traffic against a behavioural model of the
// round-robin mux, with a per-channel scoreboard acting as the loopback demux.
module tb_mux_8to1_rr;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  in_valid = '0, in_last = '0, in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid, out_last, busy, out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [2:0]  sel;
    int          tests = 0, fails = 0, n_rx = 0;
    bit          gap_en = 1'b0;
    logic [7:0]  acc = '0;
    logic [8:0]  dq[8][$];
    logic [8:0]  sq[8][$];
    bit          m_ov, m_ol, m_lk;
    logic [7:0]  m_od;
    int          m_sel, m_ptr = 7, m_lch;

    always #5 clk = ~clk;

    mux_8to1_rr dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .sel(sel),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which channel the rules say is granted right now (-1 for none).
    function automatic int exp_pick();
        if (m_lk) return in_valid[m_lch] ? m_lch : -1;
        for (int k = 1; k <= 8; k++) if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        return -1;
    endfunction

    task automatic model_check();
        int g = exp_pick();
        logic [7:0] er = (g >= 0 && (!m_ov || out_ready)) ? 8'(1 << g) : 8'h00;
        chk("m_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("m_data", 32'(out_data), 32'(m_od));
            chk("m_last", 32'(out_last), 32'(m_ol));
            chk("m_sel", 32'(sel), m_sel);
        end
        chk("m_busy", 32'(busy), 32'(m_lk));
        chk("m_ready", 32'(in_ready), 32'(er));
    endtask

    task automatic model_step();
        int g = exp_pick();
        if (!m_ov || out_ready) begin
            if (g >= 0) begin
                m_ov  <= 1'b1;
                m_od  <= in_data[g*8 +: 8];
                m_ol  <= in_last[g];
                m_sel <= g;
                m_ptr <= g;
                if (!m_lk && !in_last[g]) begin
                    m_lk  <= 1'b1;
                    m_lch <= g;
                end else if (m_lk && in_last[g]) m_lk <= 1'b0;
            end else m_ov <= 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ov <= 1'b0; m_od <= '0; m_ol <= 1'b0; m_sel <= 0;
            m_lk <= 1'b0; m_ptr <= 7; m_lch <= 0;
            for (int i = 0; i < 8; i++) sq[i].delete();
            acc <= '0;
        end else begin
            model_check();
            if (out_valid && out_ready) begin
                chk("sb_occupancy", 32'(sq[sel].size() > 0), 32'd1);
                if (sq[sel].size() > 0) begin
                    chk("sb_route", 32'({out_last, out_data}), 32'(sq[sel][0]));
                    void'(sq[sel].pop_front());
                    n_rx <= n_rx + 1;
                end
            end
            for (int i = 0; i < 8; i++)
                if (in_valid[i] && in_ready[i]) sq[i].push_back({in_last[i], in_data[i*8 +: 8]});
            acc <= in_valid & in_ready;
            model_step();
        end
    end

    // Upstream sources: each channel presents the head of its beat queue.
    initial forever begin
        @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
            if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
            in_valid[i] = dq[i].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0);
            in_data[i*8 +: 8] = dq[i].size() > 0 ? dq[i][0][7:0] : 8'h00;
            in_last[i] = dq[i].size() > 0 ? dq[i][0][8] : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic l);
        dq[ch].push_back({l, d});
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) dq[i].delete();
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int e_sel[6]  = '{2, 2, 2, 5, 2, 5};
        int e_data[6] = '{'h01, 'h02, 'h03, 'h50, 'h04, 'h51};
        int e_busy[6] = '{1, 1, 0, 0, 0, 0};
        int rx0;
        // single beat from ch3
        do_reset();
        out_ready = 1'b1;
        push(3, 8'hA5, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_sel", 32'(sel), 32'd3);
        chk("t1_last", 32'(out_last), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        // all channels busy with single-beat packets
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) for (int i = 0; i < 8; i++) push(i, 8'(8'h10 + i), 1'b1);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_sel", 32'(sel), k % 8);
            chk("t2_data", 32'(out_data), 32'h10 + k % 8);
            @(negedge clk);
        end
        // 3-beat ch2 packet locks out ch5
        do_reset();
        out_ready = 1'b1;
        push(2, 8'h01, 1'b0); push(2, 8'h02, 1'b0); push(2, 8'h03, 1'b1); push(2, 8'h04, 1'b1);
        push(5, 8'h50, 1'b1); push(5, 8'h51, 1'b1);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("t3_sel", 32'(sel), e_sel[k]);
            chk("t3_data", 32'(out_data), e_data[k]);
            chk("t3_busy", 32'(busy), e_busy[k]);
            @(negedge clk);
        end
        // output held under backpressure
        do_reset();
        out_ready = 1'b0;
        push(1, 8'h55, 1'b1); push(1, 8'h56, 1'b1);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("t4_hold_data", 32'(out_data), 32'h55);
            chk("t4_hold_sel", 32'(sel), 32'd1);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
            if (k < 3) @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t4_next_data", 32'(out_data), 32'h56);
        chk("t4_next_valid", 32'(out_valid), 32'd1);
        // reset in the middle of a ch6 packet
        do_reset();
        out_ready = 1'b1;
        push(6, 8'h60, 1'b0); push(6, 8'h61, 1'b0); push(6, 8'h62, 1'b0); push(6, 8'h63, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("t5_b0", 32'(out_data), 32'h60);
        chk("t5_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t5_b1", 32'(out_data), 32'h61);
        do_reset();
        push(6, 8'h66, 1'b1); push(0, 8'h0A, 1'b1);
        @(posedge clk); @(negedge clk);
        chk("t5_first_sel", 32'(sel), 32'd0);
        chk("t5_first_data", 32'(out_data), 32'h0A);
        @(negedge clk);
        chk("t5_second_sel", 32'(sel), 32'd6);
        chk("t5_second_data", 32'(out_data), 32'h66);
        // random loopback traffic with valid gaps and backpressure
        do_reset();
        rx0 = n_rx;
        gap_en = 1'b1;
        repeat (400) begin
            int ch, n;
            tick();
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 5) == 0) begin
                ch = $urandom_range(0, 7);
                n = $urandom_range(1, 3);
                for (int b = 0; b < n; b++) push(ch, 8'($urandom), b == n - 1);
            end
        end
        gap_en = 1'b0;
        out_ready = 1'b1;
        repeat (300) tick();
        for (int i = 0; i < 8; i++) begin
            chk("t6_drain_src", dq[i].size(), 32'd0);
            chk("t6_drain_sb", sq[i].size(), 32'd0);
        end
        chk("t6_beats", 32'((n_rx - rx0) >= 30), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_8to1_rr.md
Name: mux_8to1_rr

Overview:
- Gathering end of the 1:8 demux path. Merges up to N_CH input streams into one output stream and tags each beat with its source index on `sel`, so a downstream demux_1to8 can route it back out.
- Uses a valid/ready handshake on every port, round-robin arbitration, and packet locking via `last`.
- Has a registered output stage that sustains full throughput.

Parameters:
- N_CH, 8, number of input channels (power of 2, 2..16)
- DATA_W, 8, data width per beat
- SEL_W, $clog2(N_CH), width of source tag (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_CH  per-channel beat valid
- in_data  input  N_CH*DATA_W  per-channel data, channel i at [i*DATA_W +: DATA_W]
- in_last  input  N_CH  per-channel end-of-packet flag
- in_ready  output  N_CH  per-channel accept
- out_valid  output  1  output beat valid
- out_data  output  DATA_W  output data
- out_last  output  1  end-of-packet of output beat
- sel  output  SEL_W  source channel of output beat
- out_ready  input  1  downstream accept
- busy  output  1  high while a packet is locked (LOCKED state)

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, sel=0, busy=0, state=IDLE.
  - Round-robin pointer last_grant=N_CH-1, so channel 0 has top priority first.
- Output register (single entry):
  - load_en = !out_valid | out_ready.
  - A transfer on any port occurs when valid&ready are both high at a rising edge.
- Arbitration:
  - In IDLE, grant goes to the first channel with in_valid=1, searching from last_grant+1 upward with wrap (N_CH-1 -> 0).
  - Grant is combinational and one-hot.
  - in_ready[i] = grant[i] & load_en. in_ready is 0 for all non-granted channels.
- Transfer of the granted channel's beat:
  - On transfer, out_data/out_last/sel take that channel's data/last/index on the next edge, and out_valid=1.
  - Latency: input accept to out_valid is 1 cycle.
  - Throughput: 1 beat/cycle while out_ready=1.
- State machine:
  - IDLE -> LOCKED on transfer of a beat with in_last=0. The locked channel is stored and last_grant is updated to it.
  - IDLE stays IDLE on transfer of a beat with in_last=1 (single-beat packet). last_grant is updated to the channel.
  - LOCKED: grant is fixed to the locked channel regardless of other valids. A gap in that channel's in_valid stalls the output; there is no re-arbitration.
  - LOCKED -> IDLE on transfer of a locked-channel beat with in_last=1.
  - busy = (state==LOCKED).
- Output hold: while out_valid=1 and out_ready=0, out_data/out_last/sel are stable and all in_ready=0.
- Simultaneous events: out_ready=1 with a new grant in the same cycle means the old beat leaves and the new beat loads; there is no bubble.
- No valids:
  - out_valid drops after the current beat is taken.
  - last_grant is unchanged.
  - The state machine stays in IDLE.
- Reset mid-packet: all state clears immediately. A partially forwarded packet is truncated (no out_last is emitted); upstream is responsible for recovery.
- in_data of non-granted channels is ignored and never appears on out_data.

Decomposition:
- Package mux_pkg holds:
  - state enum typedef {IDLE, LOCKED}
  - default N_CH/DATA_W localparams
  - a function rr_pick(valid, last_grant) returning a one-hot grant
- Sub-module rr_arbiter (purely combinational priority rotate + registered pointer update) is natural. The lock FSM and output register stay in the top.

Test Plan:
- Reset then ch3 sends a single beat 0xA5 with last=1, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, sel=3, out_last=1, busy=0.
- All 8 channels hold valid with single-beat packets, data=0x10+i, out_ready=1 -> outputs appear in order sel=0,1,...,7,0 with no idle cycles, and data matches.
- ch2 sends a 3-beat packet (0x01,0x02,0x03 with last on the 3rd) while ch5 stays valid throughout -> sel=2 for all 3 beats with busy=1; ch5 (sel=5) follows only after out_last; ch2 is skipped on the next round.
- Output 0x55 from ch1 pending, out_ready held 0 for 4 cycles -> out_data=0x55 and sel=1 stay stable and in_ready=0; when out_ready=1, the next beat follows with no gap.
- Assert rst_n=0 mid-way through a 4-beat ch6 packet (after 2 beats) -> out_valid=0, busy=0, sel=0 immediately; after release, ch0 is served before ch6 when both are valid.
- Loopback: mux output feeds demux_1to8 via sel, with random traffic on 8 channels -> every beat arrives on the demux output index equal to its source channel, in per-channel order.
